hash_table_cmd_queue: RTL and testbench



---
 rtl/hash_table_pkg.sv | 29 ++
 rtl/hash_table_sync_fifo.sv | 47 ++++
 rtl/hash_table_cmd_queue.sv | 221 ++++++++++++++++++++++
 tb/tb_hash_table_cmd_queue.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_table_pkg.sv
// Shared definitions for the hash_table command queue front-end:
// operation encodings, FSM state type and packed-record width helpers.
package hash_table_pkg;

  localparam int OP_WIDTH = 2;

  localparam logic [OP_WIDTH-1:0] OP_INSERT = 2'b00;
  localparam logic [OP_WIDTH-1:0] OP_DELETE = 2'b01;
  localparam logic [OP_WIDTH-1:0] OP_SEARCH = 2'b10;
  localparam logic [OP_WIDTH-1:0] OP_RSVD   = 2'b11;

  // Issue sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Width of a queued command record {op, key, value, tag}
  function automatic int cmd_bits(input int key_w, input int value_w, input int tag_w);
    return OP_WIDTH + key_w + value_w + tag_w;
  endfunction

  // Width of a response record {tag, value, error, timeout, collision}
  function automatic int resp_bits(input int value_w, input int coll_w, input int tag_w);
    return tag_w + value_w + 2 + coll_w;
  endfunction

endpackage

// File: rtl/hash_table_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; full/empty/count derived from
// the pointers. Callers only push when not full (or when popping in the
// same cycle) and only pop when not empty.
module hash_table_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Pointer advance on push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage write; contents need no reset since empty gates the head
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;

endmodule

// File: rtl/hash_table_cmd_queue.sv
// Command/response queue in front of hash_table. Commands are buffered,
// issued one at a time over the op_en/op_done level handshake, and tagged
// results are returned in command order. Hung table ops are aborted after
// TIMEOUT_CYCLES.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high; ready never depends on valid, and response data holds
// steady while valid is high and ready is low.
//
// Optional build macro HASH_TABLE_CMDQ_STATS_EN adds saturating
// stat_issued / stat_errors / stat_timeouts counters.
module hash_table_cmd_queue
  import hash_table_pkg::*;
#(
  parameter int KEY_WIDTH      = 32,
  parameter int VALUE_WIDTH    = 32,
  parameter int COLL_WIDTH     = 2,
  parameter int TAG_WIDTH      = 4,
  parameter int CMD_DEPTH      = 4,
  parameter int RESP_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [KEY_WIDTH-1:0]        cmd_key,
  input  logic [VALUE_WIDTH-1:0]      cmd_value,
  input  logic [TAG_WIDTH-1:0]        cmd_tag,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [TAG_WIDTH-1:0]        resp_tag,
  output logic [VALUE_WIDTH-1:0]      resp_value,
  output logic                        resp_error,
  output logic                        resp_timeout,
  output logic [COLL_WIDTH-1:0]       resp_collision,
  output logic [KEY_WIDTH-1:0]        ht_key_in,
  output logic [VALUE_WIDTH-1:0]      ht_value_in,
  output logic [1:0]                  ht_op_sel,
  output logic                        ht_op_en,
  input  logic [VALUE_WIDTH-1:0]      ht_value_out,
  input  logic                        ht_op_done,
  input  logic                        ht_op_error,
  input  logic [COLL_WIDTH-1:0]       ht_collision_count,
`ifdef HASH_TABLE_CMDQ_STATS_EN
  output logic [15:0]                 stat_issued,
  output logic [15:0]                 stat_errors,
  output logic [15:0]                 stat_timeouts,
`endif
  output state_t                      dbg_state,
  output logic [$clog2(CMD_DEPTH):0]  dbg_cmd_count,
  output logic [$clog2(RESP_DEPTH):0] dbg_resp_count
);

  localparam int CMD_W  = cmd_bits(KEY_WIDTH, VALUE_WIDTH, TAG_WIDTH);
  localparam int RESP_W = resp_bits(VALUE_WIDTH, COLL_WIDTH, TAG_WIDTH);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic [1:0]             op;
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
    logic [TAG_WIDTH-1:0]   tag;
  } cmd_t;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]   tag;
    logic [VALUE_WIDTH-1:0] value;
    logic                   error;
    logic                   timeout;
    logic [COLL_WIDTH-1:0]  collision;
  } resp_t;

  cmd_t   cmd_in;
  cmd_t   cmd_head;
  resp_t  resp_in;
  resp_t  resp_head;

  logic   cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic   resp_push, resp_pop, resp_full, resp_empty;

  state_t                 state_q, state_d;
  logic                   issue_load;
  logic [TAG_WIDTH-1:0]   cur_tag;
  logic [TMO_W-1:0]       tmo_cnt;

  assign cmd_in    = {cmd_op, cmd_key, cmd_value, cmd_tag};
  assign cmd_ready = !rst && !cmd_full;
  assign cmd_push  = cmd_valid && cmd_ready;

  assign resp_valid = !resp_empty;
  assign resp_pop   = resp_valid && resp_ready;

  hash_table_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_push),
    .push_data (cmd_in),
    .pop       (cmd_pop),
    .pop_data  (cmd_head),
    .full      (cmd_full),
    .empty     (cmd_empty),
    .count     (dbg_cmd_count)
  );

  hash_table_sync_fifo #(.WIDTH(RESP_W), .DEPTH(RESP_DEPTH)) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (resp_push),
    .push_data (resp_in),
    .pop       (resp_pop),
    .pop_data  (resp_head),
    .full      (resp_full),
    .empty     (resp_empty),
    .count     (dbg_resp_count)
  );

  // Response head is only meaningful while valid; otherwise drive zeros
  assign resp_tag       = resp_valid ? resp_head.tag       : '0;
  assign resp_value     = resp_valid ? resp_head.value     : '0;
  assign resp_error     = resp_valid ? resp_head.error     : 1'b0;
  assign resp_timeout   = resp_valid ? resp_head.timeout   : 1'b0;
  assign resp_collision = resp_valid ? resp_head.collision : '0;

  assign dbg_state = state_q;

  // Next-state and FIFO control; a response slot must be free (or freeing
  // this cycle) before a command leaves the queue, so the single in-flight
  // op always has somewhere to land
  always_comb begin
    state_d    = state_q;
    cmd_pop    = 1'b0;
    resp_push  = 1'b0;
    resp_in    = '0;
    issue_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!cmd_empty && (!resp_full || resp_pop)) begin
          cmd_pop = 1'b1;
          case (cmd_head.op)
            OP_INSERT, OP_DELETE, OP_SEARCH: begin
              issue_load = 1'b1;
              state_d    = ST_ISSUE;
            end
            OP_RSVD: begin
              resp_push     = 1'b1;
              resp_in.tag   = cmd_head.tag;
              resp_in.error = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_ISSUE: begin
        if (ht_op_done) begin
          resp_push         = 1'b1;
          resp_in.tag       = cur_tag;
          resp_in.value     = (ht_op_sel == OP_SEARCH) ? ht_value_out : '0;
          resp_in.error     = ht_op_error;
          resp_in.collision = ht_collision_count;
          state_d           = ST_GAP;
        end else if (tmo_cnt == TMO_LAST) begin
          resp_push       = 1'b1;
          resp_in.tag     = cur_tag;
          resp_in.error   = 1'b1;
          resp_in.timeout = 1'b1;
          state_d         = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, table-side request registers and timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ht_op_en    <= 1'b0;
      ht_key_in   <= '0;
      ht_value_in <= '0;
      ht_op_sel   <= '0;
      cur_tag     <= '0;
      tmo_cnt     <= '0;
    end else begin
      state_q <= state_d;
      if (issue_load) begin
        ht_key_in   <= cmd_head.key;
        ht_value_in <= cmd_head.value;
        ht_op_sel   <= cmd_head.op;
        ht_op_en    <= 1'b1;
        cur_tag     <= cmd_head.tag;
        tmo_cnt     <= '0;
      end else if (state_q == ST_ISSUE) begin
        if (state_d == ST_GAP) ht_op_en <= 1'b0;
        else                   tmo_cnt  <= tmo_cnt + TMO_W'(1);
      end
    end
  end

`ifdef HASH_TABLE_CMDQ_STATS_EN
  // Saturating activity counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued   <= '0;
      stat_errors   <= '0;
      stat_timeouts <= '0;
    end else begin
      if (state_q == ST_ISSUE && state_d == ST_GAP && stat_issued != 16'hFFFF)
        stat_issued <= stat_issued + 16'd1;
      if (resp_push && resp_in.error && stat_errors != 16'hFFFF)
        stat_errors <= stat_errors + 16'd1;
      if (resp_push && resp_in.timeout && stat_timeouts != 16'hFFFF)
        stat_timeouts <= stat_timeouts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hash_table_cmd_queue.sv
// Bench for hash_table_cmd_queue: a behavioural hash table stub answers the
// table handshake, a dictionary reference model predicts every response at
// command acceptance, and a monitor pops predictions as responses leave.
`timescale 1ns/1ps
module tb_hash_table_cmd_queue;
  import hash_table_pkg::*;

  localparam int KW = 32;
  localparam int VW = 32;
  localparam int CW = 2;
  localparam int TW = 4;
  localparam int CD = 4;
  localparam int RD = 4;
  localparam int TO = 8;
  localparam int RW = TW + VW + 2 + CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [KW-1:0] cmd_key;
  logic [VW-1:0] cmd_value;
  logic [TW-1:0] cmd_tag;
  logic          resp_valid;
  logic          resp_ready;
  logic [TW-1:0] resp_tag;
  logic [VW-1:0] resp_value;
  logic          resp_error;
  logic          resp_timeout;
  logic [CW-1:0] resp_collision;
  logic [KW-1:0] ht_key_in;
  logic [VW-1:0] ht_value_in;
  logic [1:0]    ht_op_sel;
  logic          ht_op_en;
  logic [VW-1:0] ht_value_out;
  logic          ht_op_done;
  logic          ht_op_error;
  logic [CW-1:0] ht_collision_count;
  state_t        dbg_state;
  logic [2:0]    dbg_cmd_count;
  logic [2:0]    dbg_resp_count;

  hash_table_cmd_queue #(
    .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .COLL_WIDTH(CW), .TAG_WIDTH(TW),
    .CMD_DEPTH(CD), .RESP_DEPTH(RD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_key(cmd_key), .cmd_value(cmd_value), .cmd_tag(cmd_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_tag(resp_tag),
    .resp_value(resp_value), .resp_error(resp_error), .resp_timeout(resp_timeout),
    .resp_collision(resp_collision),
    .ht_key_in(ht_key_in), .ht_value_in(ht_value_in), .ht_op_sel(ht_op_sel),
    .ht_op_en(ht_op_en), .ht_value_out(ht_value_out), .ht_op_done(ht_op_done),
    .ht_op_error(ht_op_error), .ht_collision_count(ht_collision_count),
    .dbg_state(dbg_state), .dbg_cmd_count(dbg_cmd_count), .dbg_resp_count(dbg_resp_count)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  logic [RW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- behavioural hash table stub ----------------
  int            stub_delay = 0;
  bit            stub_hang  = 1'b0;
  int            stub_cnt   = 0;
  logic [VW-1:0] stub_tab [logic [KW-1:0]];

  initial begin
    ht_op_done = 1'b0; ht_op_error = 1'b0; ht_value_out = '0; ht_collision_count = '0;
    forever begin
      @(posedge clk); #1;
      if (rst || !ht_op_en) begin
        ht_op_done = 1'b0;
        stub_cnt   = 0;
      end else if (!ht_op_done && !stub_hang) begin
        if (stub_cnt >= stub_delay) begin
          ht_collision_count = ht_key_in[CW-1:0];
          ht_value_out       = $urandom;
          ht_op_error        = 1'b0;
          case (ht_op_sel)
            2'b00: stub_tab[ht_key_in] = ht_value_in;
            2'b01: if (stub_tab.exists(ht_key_in)) stub_tab.delete(ht_key_in);
                   else ht_op_error = 1'b1;
            2'b10: if (stub_tab.exists(ht_key_in)) ht_value_out = stub_tab[ht_key_in];
                   else begin ht_op_error = 1'b1; ht_value_out = '0; end
            default: ht_op_error = 1'b1;
          endcase
          ht_op_done = 1'b1;
        end else begin
          stub_cnt++;
        end
      end
    end
  end

  // ---------------- reference model (in command order) ----------------
  logic [VW-1:0] ref_tab [logic [KW-1:0]];

  task automatic model(input logic [1:0] op, input logic [KW-1:0] key,
                       input logic [VW-1:0] value, input logic [TW-1:0] tag,
                       output logic [RW-1:0] r);
    logic [VW-1:0] v;
    logic          e;
    logic [CW-1:0] c;
    v = '0; e = 1'b0; c = key[CW-1:0];
    if (op == 2'b11) begin
      e = 1'b1; c = '0;
    end else if (stub_hang) begin
      e = 1'b1; c = '0;
    end else if (op == 2'b00) begin
      ref_tab[key] = value;
    end else if (op == 2'b01) begin
      if (ref_tab.exists(key)) ref_tab.delete(key);
      else e = 1'b1;
    end else begin
      if (ref_tab.exists(key)) v = ref_tab[key];
      else e = 1'b1;
    end
    r = {tag, v, e, (op != 2'b11) && stub_hang, c};
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [1:0] op, input logic [KW-1:0] key,
                          input logic [VW-1:0] value, input logic [TW-1:0] tag,
                          input bit want_resp);
    logic [RW-1:0] r;
    int guard;
    cmd_op = op; cmd_key = key; cmd_value = value; cmd_tag = tag; cmd_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 300) begin
      guard++;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      fail_now("cmd_accept");
      cmd_valid = 1'b0;
      return;
    end
    if (want_resp) begin
      model(op, key, value, tag, r);
      exp_q.push_back(r);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int guard;
    guard = 0;
    @(negedge clk);
    while (exp_q.size() != 0 && guard < limit) begin
      guard++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      fail_now("drain");
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit saw_op_en = 1'b0;
  always @(negedge clk) if (ht_op_en) saw_op_en = 1'b1;

  always @(negedge clk) begin
    logic [RW-1:0] got;
    logic [RW-1:0] e;
    if (!rst && resp_valid && resp_ready) begin
      got = {resp_tag, resp_value, resp_error, resp_timeout, resp_collision};
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL resp_unexpected: got %0h expected none", got);
      end else begin
        e = exp_q.pop_front();
        check("resp", 64'(got), 64'(e));
      end
    end
  end

  bit rand_ready_en = 1'b0;
  always @(posedge clk) begin
    if (rand_ready_en) begin
      #1;
      resp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int t1;
    int guard;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_key = '0; cmd_value = '0;
    cmd_tag = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_op_en", ht_op_en, 0);
    check("rst_key", ht_key_in, 0);
    check("rst_resp_tag", resp_tag, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Insert then search, with issue latency check
    @(posedge clk); #1;
    resp_ready = 1'b1; stub_delay = 0;
    send_cmd(2'b00, 32'd1, 32'd2, 4'd3, 1'b1);
    check("lat_not_yet", ht_op_en, 0);
    @(posedge clk); #1;
    check("lat_op_en", ht_op_en, 1);
    check("lat_key", ht_key_in, 1);
    check("lat_value", ht_value_in, 2);
    check("lat_sel", ht_op_sel, 0);
    send_cmd(2'b10, 32'd1, 32'd0, 4'd4, 1'b1);
    wait_drain(100);

    // Response FIFO full stalls issue but not acceptance
    resp_ready = 1'b0; stub_delay = 1;
    for (int i = 0; i < 5; i++) send_cmd(2'b00, KW'(16 + i), $urandom, 4'(8 + i), 1'b1);
    repeat (40) @(posedge clk);
    saw_op_en = 1'b0;
    repeat (10) @(negedge clk);
    check("stall_no_issue", saw_op_en, 0);
    check("stall_resp_valid", resp_valid, 1);
    check("stall_resp_count", dbg_resp_count, 4);
    check("stall_cmd_count", dbg_cmd_count, 1);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    guard = 0;
    while (!ht_op_en && guard < 20) begin guard++; @(negedge clk); end
    check("stall_release_issue", ht_op_en, 1);
    wait_drain(200);

    // Reserved op never touches the table
    saw_op_en = 1'b0;
    send_cmd(2'b11, 32'd5, 32'd0, 4'd7, 1'b1);
    wait_drain(50);
    check("rsvd_no_op_en", saw_op_en, 0);

    // Timeout on a hung table, then normal issue
    stub_hang = 1'b1;
    send_cmd(2'b10, 32'd1, 32'd0, 4'd5, 1'b1);
    guard = 0;
    while (!ht_op_en && guard < 20) begin guard++; @(negedge clk); end
    t0 = cyc;
    guard = 0;
    while (!resp_valid && guard < 40) begin guard++; @(negedge clk); end
    t1 = cyc;
    check("tmo_latency", 64'(t1 - t0), 64'(TO));
    wait_drain(50);
    stub_hang = 1'b0;
    send_cmd(2'b10, 32'd1, 32'd0, 4'd6, 1'b1);
    wait_drain(50);

    // Delete and search of an absent key
    send_cmd(2'b01, 32'd9, 32'd0, 4'd1, 1'b1);
    send_cmd(2'b10, 32'd9, 32'd0, 4'd2, 1'b1);
    wait_drain(100);

    // Reset while an op is in ISSUE with commands queued
    stub_hang = 1'b1;
    for (int i = 0; i < 3; i++) send_cmd(2'b10, 32'd20, 32'd0, 4'(9 + i), 1'b0);
    guard = 0;
    while (!ht_op_en && guard < 20) begin guard++; @(negedge clk); end
    check("mid_op_en_before", ht_op_en, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    check("mid_rst_op_en", ht_op_en, 0);
    check("mid_rst_cmd_count", dbg_cmd_count, 0);
    @(posedge clk); #1;
    rst = 1'b0; stub_hang = 1'b0;
    @(negedge clk);
    check("mid_post_cmd_ready", cmd_ready, 1);
    saw_op_en = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_no_reissue", saw_op_en, 0);
    check("mid_no_resp", resp_valid, 0);

    // Randomised traffic with random consumer back-pressure
    @(posedge clk); #1;
    rand_ready_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      stub_delay = $urandom_range(0, 4);
      send_cmd(2'($urandom_range(0, 3)), KW'($urandom_range(0, 7)), $urandom, 4'(i), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
      end
    end
    rand_ready_en = 1'b0;
    @(posedge clk); #2;
    resp_ready = 1'b1;
    wait_drain(3000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
